// File: rtl/ifetch_unit.sv
// Instruction fetch stage: owns the fetch PC, issues word requests to instruction
// memory and queues returned instructions (with their PCs) in order for decode.
module ifetch_unit #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 2
) (
  input  logic            clk,
  input  logic            reset,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [XLEN-1:0] imem_rsp_data_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o,
  output logic [XLEN-1:0] fetch_pc_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SW = CW + 2;

  logic [XLEN-1:0] fetchPc_q, fetchPc_d;
  logic [CW-1:0]   outstanding_q, outstanding_d;
  logic [CW-1:0]   discard_q, discard_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   inflRd_q, inflRd_d;
  logic [AW-1:0]   inflWr_q, inflWr_d;
  logic [AW-1:0]   headPtr_q, headPtr_d;
  logic [AW-1:0]   tailPtr_q, tailPtr_d;

  logic [XLEN-1:0] inflightPc [DEPTH];
  logic [XLEN-1:0] queuePc    [DEPTH];
  logic [XLEN-1:0] queueInstr [DEPTH];

  logic          pop;
  logic          accept;
  logic          rspKeep;
  logic          credit;
  logic [SW-1:0] inUse;
  logic [CW:0]   staleTotal;
  logic [CW:0]   staleLeft;
  logic [1:0]    unused_redirect_lsbs;

  function automatic logic [AW-1:0] bumpPtr(input logic [AW-1:0] ptr);
    if (ptr == AW'(DEPTH - 1)) bumpPtr = '0;
    else                       bumpPtr = ptr + 1'b1;
  endfunction

  // Every slot is either in flight, waiting to be thrown away, or queued; a pop frees one this cycle.
  assign inUse  = SW'(outstanding_q) + SW'(discard_q) + SW'(count_q);
  assign credit = inUse < SW'(DEPTH);

  assign pop              = if_valid_o && if_ready_i;
  assign imem_req_valid_o = !reset && !redirect_valid_i && (credit || pop);
  assign accept           = imem_req_valid_o && imem_req_ready_i;
  assign rspKeep          = imem_rsp_valid_i && !redirect_valid_i &&
                            (discard_q == '0) && (outstanding_q != '0);

  // A response landing on a redirect cycle retires one stale request immediately.
  assign staleTotal = (CW+1)'(discard_q) + (CW+1)'(outstanding_q);
  assign staleLeft  = staleTotal - (CW+1)'(imem_rsp_valid_i && (staleTotal != '0));

  assign unused_redirect_lsbs = redirect_pc_i[1:0];

  assign imem_req_addr_o = fetchPc_q;
  assign fetch_pc_o      = fetchPc_q;
  assign if_valid_o      = (count_q != '0) && !redirect_valid_i;
  assign if_pc_o         = queuePc[headPtr_q];
  assign if_instr_o      = queueInstr[headPtr_q];

  always_comb begin
    fetchPc_d     = fetchPc_q;
    outstanding_d = outstanding_q;
    discard_d     = discard_q;
    count_d       = count_q;
    inflRd_d      = inflRd_q;
    inflWr_d      = inflWr_q;
    headPtr_d     = headPtr_q;
    tailPtr_d     = tailPtr_q;
    if (redirect_valid_i) begin
      fetchPc_d     = {redirect_pc_i[XLEN-1:2], 2'b00};
      outstanding_d = '0;
      discard_d     = staleLeft[CW-1:0];
      count_d       = '0;
      inflRd_d      = '0;
      inflWr_d      = '0;
      headPtr_d     = '0;
      tailPtr_d     = '0;
    end else begin
      if (accept) begin
        fetchPc_d = fetchPc_q + XLEN'(4);
        inflWr_d  = bumpPtr(inflWr_q);
      end
      if (imem_rsp_valid_i && (discard_q != '0)) begin
        discard_d = discard_q - 1'b1;
      end
      if (rspKeep) begin
        inflRd_d  = bumpPtr(inflRd_q);
        tailPtr_d = bumpPtr(tailPtr_q);
      end
      if (pop) begin
        headPtr_d = bumpPtr(headPtr_q);
      end
      outstanding_d = outstanding_q + CW'(accept) - CW'(rspKeep);
      count_d       = count_q + CW'(rspKeep) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetchPc_q     <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
      count_q       <= '0;
      inflRd_q      <= '0;
      inflWr_q      <= '0;
      headPtr_q     <= '0;
      tailPtr_q     <= '0;
    end else begin
      fetchPc_q     <= fetchPc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
      count_q       <= count_d;
      inflRd_q      <= inflRd_d;
      inflWr_q      <= inflWr_d;
      headPtr_q     <= headPtr_d;
      tailPtr_q     <= tailPtr_d;
    end
  end

  // Payload storage needs no reset; the pointers and counts decide what is live.
  always_ff @(posedge clk) begin
    if (accept) begin
      inflightPc[inflWr_q] <= fetchPc_q;
    end
    if (rspKeep && !reset) begin
      queuePc[tailPtr_q]    <= inflightPc[inflRd_q];
      queueInstr[tailPtr_q] <= imem_rsp_data_i;
    end
  end

endmodule
